sbus_cycle_master: RTL and testbench

Synthesizable, parametrised master for the external asynchronous-strobe parallel bus (address, bidirectional data, active-low RD_B/WR_B). It turns a valid/ready command stream of single or burst reads and writes into bus cycles with configurable setup, strobe, hold and gap timing. It returns read data on a valid/ready response stream with backpressure. It sits between an on-chip sequencer or host bridge and the pad-level bus drivers.

---
 rtl/sbus_master_pkg.sv | 25 ++
 rtl/sbus_cycle_master.sv | 209 ++++++++++++++++++++
 tb/tb_sbus_cycle_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sbus_master_pkg.sv
// Shared types and helpers for the asynchronous-strobe bus master.
// Holds the cycle-phase state encoding and the phase-counter width helper.
package sbus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Phase counter must hold the longest per-state countdown (max - 1), so
  // sizing for max itself leaves headroom; never narrower than one bit.
  function automatic int phase_width(input int setup_c, input int strobe_c,
                                     input int hold_c, input int gap_c);
    int m;
    m = setup_c;
    if (strobe_c > m) m = strobe_c;
    if (hold_c > m) m = hold_c;
    if (gap_c > m) m = gap_c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sbus_cycle_master.sv
// Command-stream to asynchronous-strobe bus cycle master with a one-entry
// read response register. Every output is a flop loaded from next-state logic.
module sbus_cycle_master
  import sbus_master_pkg::*;
#(
  parameter int ABUSWIDTH = 16,
  parameter int DBUSWIDTH = 8,
  parameter logic [ABUSWIDTH-1:0] BASE_ADDR = ABUSWIDTH'(16'h4000),
  parameter int LENWIDTH = 8,
  parameter int SETUP = 1,
  parameter int STROBE = 2,
  parameter int HOLD = 1,
  parameter int GAP = 5
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic                 CMD_WRITE,
  input  logic                 CMD_INC,
  input  logic [ABUSWIDTH-1:0] CMD_ADDR,
  input  logic [LENWIDTH-1:0]  CMD_LEN,
  input  logic [DBUSWIDTH-1:0] CMD_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [DBUSWIDTH-1:0] RSP_DATA,
  output logic                 RSP_LAST,
  output logic [ABUSWIDTH-1:0] BUS_ADD,
  output logic [DBUSWIDTH-1:0] BUS_DATA_OUT,
  output logic                 BUS_DATA_OE,
  input  logic [DBUSWIDTH-1:0] BUS_DATA_IN,
  output logic                 BUS_RD_B,
  output logic                 BUS_WR_B,
  output logic                 BUSY
);

  localparam int PW = phase_width(SETUP, STROBE, HOLD, GAP);
  localparam logic [PW-1:0] SETUP_LD  = PW'(SETUP - 1);
  localparam logic [PW-1:0] STROBE_LD = PW'(STROBE - 1);
  localparam logic [PW-1:0] HOLD_LD   = PW'(HOLD - 1);
  localparam logic [PW-1:0] GAP_LD    = PW'((GAP > 0) ? GAP - 1 : 0);

  state_e               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [LENWIDTH-1:0]  beat_q, beat_d;
  logic [ABUSWIDTH-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic                 inc_q, inc_d;
  logic [DBUSWIDTH-1:0] wdata_q, wdata_d;

  logic                 rsp_valid_q, rsp_valid_d;
  logic [DBUSWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic [ABUSWIDTH-1:0] bus_add_q, bus_add_d;
  logic [DBUSWIDTH-1:0] bus_data_out_q, bus_data_out_d;
  logic                 bus_data_oe_q, bus_data_oe_d;
  logic                 bus_rd_b_q, bus_rd_b_d;
  logic                 bus_wr_b_q, bus_wr_b_d;
  logic                 in_beat;
  logic                 phase_done;
  logic                 rsp_blocked;

  assign phase_done  = (phase_q == '0);
  assign rsp_blocked = rsp_valid_q && !RSP_READY;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    write_d = write_q;
    inc_d   = inc_q;
    wdata_d = wdata_q;
    // The response register drains on handshake; a fresh sample below wins.
    rsp_valid_d = rsp_blocked;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q && rsp_blocked;

    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          write_d = CMD_WRITE;
          inc_d   = CMD_INC;
          wdata_d = CMD_WDATA;
          addr_d  = CMD_ADDR + BASE_ADDR;
          beat_d  = CMD_LEN;
          phase_d = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!phase_done) begin
          phase_d = phase_q - PW'(1);
        end else if (!(!write_q && rsp_blocked)) begin
          // A read only strobes once its sample is guaranteed a free register.
          phase_d = STROBE_LD;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (!phase_done) begin
          phase_d = phase_q - PW'(1);
        end else begin
          if (!write_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = BUS_DATA_IN;
            rsp_last_d  = (beat_q == '0);
          end
          phase_d = HOLD_LD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!phase_done) begin
          phase_d = phase_q - PW'(1);
        end else if (beat_q != '0) begin
          beat_d  = beat_q - LENWIDTH'(1);
          addr_d  = inc_q ? addr_q + ABUSWIDTH'(1) : addr_q;
          phase_d = SETUP_LD;
          state_d = ST_SETUP;
        end else if (GAP > 0) begin
          phase_d = GAP_LD;
          state_d = ST_GAP;
        end else begin
          phase_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!phase_done) begin
          phase_d = phase_q - PW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        phase_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pad-facing outputs are derived from the upcoming state so they are flops.
  always_comb begin
    in_beat = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    cmd_ready_d    = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
    bus_add_d      = in_beat ? addr_d : '0;
    bus_data_oe_d  = in_beat && write_d;
    bus_data_out_d = bus_data_oe_d ? wdata_d : '0;
    bus_rd_b_d     = !((state_d == ST_STROBE) && !write_d);
    bus_wr_b_d     = !((state_d == ST_STROBE) && write_d);
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      beat_q         <= '0;
      addr_q         <= '0;
      write_q        <= 1'b0;
      inc_q          <= 1'b0;
      wdata_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_last_q     <= 1'b0;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      bus_add_q      <= '0;
      bus_data_out_q <= '0;
      bus_data_oe_q  <= 1'b0;
      bus_rd_b_q     <= 1'b1;
      bus_wr_b_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      beat_q         <= beat_d;
      addr_q         <= addr_d;
      write_q        <= write_d;
      inc_q          <= inc_d;
      wdata_q        <= wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_last_q     <= rsp_last_d;
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
      bus_add_q      <= bus_add_d;
      bus_data_out_q <= bus_data_out_d;
      bus_data_oe_q  <= bus_data_oe_d;
      bus_rd_b_q     <= bus_rd_b_d;
      bus_wr_b_q     <= bus_wr_b_d;
    end
  end

  assign CMD_READY    = cmd_ready_q;
  assign BUSY         = busy_q;
  assign RSP_VALID    = rsp_valid_q;
  assign RSP_DATA     = rsp_data_q;
  assign RSP_LAST     = rsp_last_q;
  assign BUS_ADD      = bus_add_q;
  assign BUS_DATA_OUT = bus_data_out_q;
  assign BUS_DATA_OE  = bus_data_oe_q;
  assign BUS_RD_B     = bus_rd_b_q;
  assign BUS_WR_B     = bus_wr_b_q;

endmodule

// File: tb/tb_sbus_cycle_master.sv
// Directed bench for sbus_cycle_master: per-cycle traces of each command are
// compared with hand-derived cycle numbers, addresses and read data.
module tb_sbus_cycle_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_inc;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [7:0]  rsp_data;
  logic [15:0] bus_add;
  logic [7:0]  bus_data_out, bus_data_in;
  logic        bus_data_oe, bus_rd_b, bus_wr_b, busy;

  // Pad model: fixed byte, or a byte derived from the address, while RD_B is low.
  logic        pad_mode;
  logic [7:0]  pad_fixed;
  assign bus_data_in = bus_rd_b ? 8'hFF : (pad_mode ? (bus_add[7:0] ^ 8'h3C) : pad_fixed);

  always #5 clk = ~clk;

  sbus_cycle_master #(
    .ABUSWIDTH(16), .DBUSWIDTH(8), .BASE_ADDR(16'h4000), .LENWIDTH(8),
    .SETUP(1), .STROBE(2), .HOLD(1), .GAP(5)
  ) dut (
    .BUS_CLK(clk), .BUS_RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_INC(cmd_inc), .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_LAST(rsp_last),
    .BUS_ADD(bus_add), .BUS_DATA_OUT(bus_data_out), .BUS_DATA_OE(bus_data_oe),
    .BUS_DATA_IN(bus_data_in), .BUS_RD_B(bus_rd_b), .BUS_WR_B(bus_wr_b), .BUSY(busy)
  );

  int checks = 0;
  int passed = 0;

  logic [15:0] tr_add [64];
  logic [7:0]  tr_do  [64];
  logic [7:0]  tr_rdat[64];
  logic        tr_rd[64], tr_wr[64], tr_oe[64], tr_rdy[64], tr_busy[64], tr_rv[64], tr_rl[64];
  logic [7:0]  rsp_dq[$];
  logic        rsp_lq[$];
  logic [15:0] stb_add[$];
  int          stb_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_cmd_ready"}, cmd_ready, 1);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_data"}, rsp_data, 0);
    chk({p, "_rsp_last"}, rsp_last, 0);
    chk({p, "_bus_add"}, bus_add, 0);
    chk({p, "_data_out"}, bus_data_out, 0);
    chk({p, "_oe"}, bus_data_oe, 0);
    chk({p, "_rd_b"}, bus_rd_b, 1);
    chk({p, "_wr_b"}, bus_wr_b, 1);
    chk({p, "_busy"}, busy, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && !cmd_ready; i++) step();
    chk("ready_wait", cmd_ready, 1);
  endtask

  // Accept one command at edge 0, then trace cycles 1..ncyc. RSP_READY is low
  // for cycles lo..hi of the trace.
  task automatic run_cmd(input logic wr, input logic inc, input logic [15:0] addr,
                         input logic [7:0] len, input logic [7:0] wd,
                         input int ncyc, input int lo, input int hi);
    logic prev_stb;
    wait_ready();
    cmd_write = wr; cmd_inc = inc; cmd_addr = addr; cmd_len = len; cmd_wdata = wd;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    rsp_dq.delete(); rsp_lq.delete(); stb_add.delete(); stb_cyc.delete();
    prev_stb = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      rsp_ready = !(c >= lo && c <= hi);
      tr_add[c] = bus_add;  tr_do[c] = bus_data_out; tr_rd[c] = bus_rd_b;
      tr_wr[c] = bus_wr_b;  tr_oe[c] = bus_data_oe;  tr_rdy[c] = cmd_ready;
      tr_busy[c] = busy;    tr_rv[c] = rsp_valid;    tr_rl[c] = rsp_last;
      tr_rdat[c] = rsp_data;
      if (rsp_valid && rsp_ready) begin
        rsp_dq.push_back(rsp_data);
        rsp_lq.push_back(rsp_last);
      end
      if ((!bus_rd_b || !bus_wr_b) && !prev_stb) begin
        stb_add.push_back(bus_add);
        stb_cyc.push_back(c);
      end
      prev_stb = !bus_rd_b || !bus_wr_b;
      step();
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_add[4];
    logic [7:0]  exp_dat[4];
    int          n_low;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_inc = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    pad_mode = 1'b0; pad_fixed = 8'h00;
    step(); step();
    rst = 1'b0;
    chk_reset_vals("por");

    // Single write: address/data/OE in cycles 1-4, strobe 2-3, ready again at 10.
    run_cmd(1'b1, 1'b0, 16'h0012, 8'd0, 8'hA5, 10, 0, -1);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("wr1_add_c%0d", c), tr_add[c], (c <= 4) ? 16'h4012 : 16'h0000);
      chk($sformatf("wr1_wr_b_c%0d", c), tr_wr[c], (c == 2 || c == 3) ? 0 : 1);
      chk($sformatf("wr1_rd_b_c%0d", c), tr_rd[c], 1);
      chk($sformatf("wr1_oe_c%0d", c), tr_oe[c], (c <= 4) ? 1 : 0);
      chk($sformatf("wr1_ready_c%0d", c), tr_rdy[c], (c == 10) ? 1 : 0);
      chk($sformatf("wr1_busy_c%0d", c), tr_busy[c], (c <= 9) ? 1 : 0);
      if (c <= 4) chk($sformatf("wr1_dout_c%0d", c), tr_do[c], 8'hA5);
    end

    // Single read with the consumer stalled so the response stays visible.
    pad_fixed = 8'h5C;
    run_cmd(1'b0, 1'b0, 16'h0003, 8'd0, 8'h00, 10, 1, 100);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("rd1_rd_b_c%0d", c), tr_rd[c], (c == 2 || c == 3) ? 0 : 1);
      chk($sformatf("rd1_wr_b_c%0d", c), tr_wr[c], 1);
      chk($sformatf("rd1_oe_c%0d", c), tr_oe[c], 0);
      chk($sformatf("rd1_add_c%0d", c), tr_add[c], (c <= 4) ? 16'h4003 : 16'h0000);
      chk($sformatf("rd1_rvalid_c%0d", c), tr_rv[c], (c >= 4) ? 1 : 0);
      chk($sformatf("rd1_rlast_c%0d", c), tr_rl[c], (c >= 4) ? 1 : 0);
    end
    chk("rd1_rdata", tr_rdat[4], 8'h5C);
    chk("rd1_held_valid", rsp_valid, 1);
    chk("rd1_held_data", rsp_data, 8'h5C);
    step();
    chk("rd1_drained", rsp_valid, 0);

    // Incrementing read burst crossing the top of the address space.
    pad_mode = 1'b1;
    exp_add[0] = 16'hFFFE; exp_add[1] = 16'hFFFF; exp_add[2] = 16'h0000; exp_add[3] = 16'h0001;
    exp_dat[0] = 8'hC2;    exp_dat[1] = 8'hC3;    exp_dat[2] = 8'h3C;    exp_dat[3] = 8'h3D;
    run_cmd(1'b0, 1'b1, 16'hBFFE, 8'd3, 8'h00, 22, 0, -1);
    chk("rdb_nrsp", rsp_dq.size(), 4);
    chk("rdb_nstb", stb_add.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rdb_stb_add%0d", i), stb_add[i], exp_add[i]);
      chk($sformatf("rdb_stb_cyc%0d", i), stb_cyc[i], 2 + 4 * i);
      chk($sformatf("rdb_data%0d", i), rsp_dq[i], exp_dat[i]);
      chk($sformatf("rdb_last%0d", i), rsp_lq[i], (i == 3) ? 1 : 0);
    end
    chk("rdb_ready_c21", tr_rdy[21], 0);
    chk("rdb_ready_c22", tr_rdy[22], 1);

    // Same burst, consumer stalled cycles 4-13: beat 2 waits in SETUP until 14.
    run_cmd(1'b0, 1'b1, 16'hBFFE, 8'd3, 8'h00, 31, 4, 13);
    n_low = 0;
    for (int c = 5; c <= 14; c++) if (!tr_rd[c]) n_low++;
    chk("rds_no_strobe_while_blocked", n_low, 0);
    chk("rds_setup_add_c10", tr_add[10], 16'hFFFF);
    chk("rds_valid_c13", tr_rv[13], 1);
    chk("rds_nrsp", rsp_dq.size(), 4);
    chk("rds_nstb", stb_cyc.size(), 4);
    chk("rds_stb_cyc1", stb_cyc[1], 15);
    chk("rds_stb_cyc2", stb_cyc[2], 19);
    chk("rds_stb_cyc3", stb_cyc[3], 23);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rds_data%0d", i), rsp_dq[i], exp_dat[i]);
      chk($sformatf("rds_last%0d", i), rsp_lq[i], (i == 3) ? 1 : 0);
    end
    chk("rds_ready_c30", tr_rdy[30], 0);
    chk("rds_ready_c31", tr_rdy[31], 1);

    // Fixed-address write burst: three pulses four cycles apart.
    run_cmd(1'b1, 1'b0, 16'h0100, 8'd2, 8'h3C, 18, 0, -1);
    chk("wrb_nstb", stb_cyc.size(), 3);
    chk("wrb_nrsp", rsp_dq.size(), 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrb_stb_cyc%0d", i), stb_cyc[i], 2 + 4 * i);
      chk($sformatf("wrb_stb_add%0d", i), stb_add[i], 16'h4100);
    end
    chk("wrb_oe_c12", tr_oe[12], 1);
    chk("wrb_oe_c13", tr_oe[13], 0);
    chk("wrb_ready_c17", tr_rdy[17], 0);
    chk("wrb_ready_c18", tr_rdy[18], 1);

    // Reset during a read strobe abandons the command.
    pad_mode = 1'b0; pad_fixed = 8'h77;
    wait_ready();
    cmd_write = 1'b0; cmd_inc = 1'b0; cmd_addr = 16'h0003; cmd_len = 8'd0;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rst_in_strobe", bus_rd_b, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("rst_mid");
    n_low = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid || !bus_rd_b || !bus_wr_b || busy) n_low++;
      step();
    end
    chk("rst_quiet_after", n_low, 0);
    run_cmd(1'b1, 1'b0, 16'h0055, 8'd0, 8'h0F, 10, 0, -1);
    chk("rst_fresh_nstb", stb_cyc.size(), 1);
    chk("rst_fresh_cyc", stb_cyc[0], 2);
    chk("rst_fresh_add", stb_add[0], 16'h4055);
    chk("rst_fresh_dout", tr_do[2], 8'h0F);
    chk("rst_fresh_ready", tr_rdy[10], 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
